// File: rtl/pavana_mem_slave_ooo.sv
// pavana_mem_slave_ooo: tagged memory responder for one slave port of the
// pavana 4x4 out-of-order crossbar.
//
// Writes land in memory at the accept edge and produce no response. Reads
// take one of DEPTH slots. Each slot holds the request ID, the read data
// captured at accept time and a 4-bit countdown. The lowest-index slot whose
// countdown has reached zero is returned each cycle. The countdown depends on
// the address, so responses can come back out of order.
//
// Handshake: a request transfers in any cycle where slave_req && slave_ack.
// slave_ack is combinational. Writes are always accepted. A read is accepted
// only while at least one slot is free, judged on the slot valid bits at the
// start of the cycle. Responses are single-cycle slave_resp pulses and have
// no backpressure.
//
// Optional build macro: PAVANA_MEM_SLAVE_INORDER_EN. When defined, every read
// uses the same latency LAT_MIN, so responses return in acceptance order.
`timescale 1ns/1ps

module pavana_mem_slave_ooo #(
    parameter int MEM_AW  = 8,
    parameter int DEPTH   = 4,
    parameter int LAT_MIN = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        slave_req,
    input  logic [31:0] slave_addr,
    input  logic        slave_cmd,
    input  logic [1:0]  slave_reqtid,
    input  logic [31:0] slave_wdata,
    output logic        slave_ack,
    output logic [1:0]  slave_resptid,
    output logic [31:0] slave_rdata,
    output logic        slave_resp
);

    localparam int WORDS = 1 << MEM_AW;

    // Word storage; contents are not reset.
    logic [31:0]       mem [WORDS];
    logic [MEM_AW-1:0] word_idx;
    logic [31:0]       mem_rd;

    // Outstanding-read slots.
    logic [DEPTH-1:0]  slot_valid;
    logic [1:0]        slot_tid  [DEPTH];
    logic [31:0]       slot_data [DEPTH];
    logic [3:0]        slot_cnt  [DEPTH];

    // One-hot slot picks for this cycle.
    logic [DEPTH-1:0]  alloc_oh;
    logic [DEPTH-1:0]  sel_oh;
    logic              any_free;
    logic              any_elig;

    // Response candidate from the selected slot.
    logic [1:0]        sel_tid;
    logic [31:0]       sel_data;

    // Handshake qualifiers.
    logic              rd_accept;
    logic              wr_accept;

    // Countdown for the read being accepted.
    logic [3:0]        lat_c;
    logic [3:0]        load_cnt;

    // Address bits that never reach the word index.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{slave_addr[31:MEM_AW+2], slave_addr[1:0]};

    assign word_idx = slave_addr[MEM_AW+1:2];
    assign mem_rd   = mem[word_idx];

    // Accept decision: writes always, reads only while a slot is free.
    always_comb begin
        slave_ack = !rst_i && slave_req && (slave_cmd || any_free);
        rd_accept = slave_ack && !slave_cmd;
        wr_accept = slave_ack && slave_cmd;
    end

    // Read latency C. The slot holds C-1 after the accept edge and becomes
    // eligible when it reaches zero, which puts the response pulse in cycle
    // T+C+1 for an uncontended read accepted in cycle T. C=0 behaves like C=1.
    always_comb begin
`ifdef PAVANA_MEM_SLAVE_INORDER_EN
        lat_c = 4'(LAT_MIN);
`else
        lat_c = 4'(LAT_MIN) + {2'b00, slave_addr[3:2]};
`endif
        load_cnt = (lat_c == 4'd0) ? 4'd0 : lat_c - 4'd1;
    end

    // Lowest-index free slot for allocation.
    always_comb begin
        alloc_oh = '0;
        any_free = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!any_free && !slot_valid[i]) begin
                alloc_oh[i] = 1'b1;
                any_free    = 1'b1;
            end
        end
    end

    // Lowest-index eligible slot for the response.
    always_comb begin
        sel_oh   = '0;
        any_elig = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!any_elig && slot_valid[i] && (slot_cnt[i] == 4'd0)) begin
                sel_oh[i] = 1'b1;
                any_elig  = 1'b1;
            end
        end
    end

    // One-hot mux of the selected slot payload.
    always_comb begin
        sel_tid  = '0;
        sel_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                sel_tid  = sel_tid  | slot_tid[i];
                sel_data = sel_data | slot_data[i];
            end
        end
    end

    // Memory write port.
    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            mem[word_idx] <= slave_wdata;
        end
    end

    // Slot lifecycle: allocate on read accept, count down, retire on select.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_tid[i]  <= '0;
                slot_data[i] <= '0;
                slot_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_accept && alloc_oh[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_tid[i]   <= slave_reqtid;
                    slot_data[i]  <= mem_rd;
                    slot_cnt[i]   <= load_cnt;
                end else if (sel_oh[i]) begin
                    slot_valid[i] <= 1'b0;
                end else if (slot_valid[i] && (slot_cnt[i] != 4'd0)) begin
                    slot_cnt[i] <= slot_cnt[i] - 4'd1;
                end
            end
        end
    end

    // Registered response port; ID and data hold when nothing is returned.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slave_resp    <= 1'b0;
            slave_resptid <= '0;
            slave_rdata   <= '0;
        end else begin
            slave_resp <= any_elig;
            if (any_elig) begin
                slave_resptid <= sel_tid;
                slave_rdata   <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_pavana_mem_slave_ooo.sv
// Directed bench for pavana_mem_slave_ooo: each scenario task drives its
// requests, checks accept decisions inline, and compares the logged response
// pulses (cycle, ID, data) against hand-computed expectations.
`timescale 1ns/1ps

module tb_pavana_mem_slave_ooo;

    logic        clk_i;
    logic        rst_i;
    logic        slave_req;
    logic [31:0] slave_addr;
    logic        slave_cmd;
    logic [1:0]  slave_reqtid;
    logic [31:0] slave_wdata;
    logic        slave_ack;
    logic [1:0]  slave_resptid;
    logic [31:0] slave_rdata;
    logic        slave_resp;

    int checks;
    int errors;
    int cyc;

    // Response log filled by the monitor.
    int          rlog_cyc[$];
    logic [1:0]  rlog_tid[$];
    logic [31:0] rlog_data[$];

    pavana_mem_slave_ooo dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .slave_req    (slave_req),
        .slave_addr   (slave_addr),
        .slave_cmd    (slave_cmd),
        .slave_reqtid (slave_reqtid),
        .slave_wdata  (slave_wdata),
        .slave_ack    (slave_ack),
        .slave_resptid(slave_resptid),
        .slave_rdata  (slave_rdata),
        .slave_resp   (slave_resp)
    );

    // Clock and cycle counter.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Response monitor, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (slave_resp === 1'b1) begin
            rlog_cyc.push_back(cyc);
            rlog_tid.push_back(slave_resptid);
            rlog_data.push_back(slave_rdata);
        end
    end

    task automatic clear_log();
        rlog_cyc.delete();
        rlog_tid.delete();
        rlog_data.delete();
    endtask

    // Present one request for the current cycle (set at the falling edge).
    task automatic drive(input logic cmd, input logic [31:0] addr,
                         input logic [1:0] tid, input logic [31:0] wd);
        @(negedge clk_i);
        slave_req    = 1'b1;
        slave_cmd    = cmd;
        slave_addr   = addr;
        slave_reqtid = tid;
        slave_wdata  = wd;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            slave_req = 1'b0;
            slave_cmd = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_i        = 1'b1;
        slave_req    = 1'b1;
        slave_cmd    = 1'b0;
        slave_addr   = 32'h0;
        slave_reqtid = 2'd0;
        slave_wdata  = 32'h0;
        repeat (3) @(negedge clk_i);
        #1;
        checks++;
        if (slave_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack: got %b expected 0", slave_ack);
        end
        checks++;
        if (slave_resp !== 1'b0 || slave_resptid !== 2'd0 || slave_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got resp=%b tid=%0d data=%h expected 0/0/00000000",
                     slave_resp, slave_resptid, slave_rdata);
        end
        @(negedge clk_i);
        rst_i     = 1'b0;
        slave_req = 1'b0;
        idle(2);
        clear_log();
    endtask

    task automatic test_write_read();
        int t0;
        drive(1'b1, 32'h10, 2'd0, 32'hDEADBEEF);
        checks++;
        if (slave_ack !== 1'b1) begin
            errors++;
            $display("FAIL wr_ack: got %b expected 1", slave_ack);
        end
        idle(4);
        checks++;
        if (rlog_cyc.size() != 0) begin
            errors++;
            $display("FAIL wr_no_resp: got %0d pulses expected 0", rlog_cyc.size());
        end
        drive(1'b0, 32'h10, 2'd1, 32'h0);
        t0 = cyc;
        checks++;
        if (slave_ack !== 1'b1) begin
            errors++;
            $display("FAIL rd_ack: got %b expected 1", slave_ack);
        end
        idle(6);
        checks++;
        if (rlog_cyc.size() != 1 || rlog_cyc[0] != t0 + 3 || rlog_tid[0] !== 2'd1
            || rlog_data[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_resp: got %0d pulses first cyc=+%0d tid=%0d data=%h expected 1 pulse cyc=+3 tid=1 data=deadbeef",
                     rlog_cyc.size(), (rlog_cyc.size() > 0) ? rlog_cyc[0] - t0 : -1,
                     (rlog_tid.size() > 0) ? rlog_tid[0] : 2'd0,
                     (rlog_data.size() > 0) ? rlog_data[0] : 32'h0);
        end
        clear_log();
    endtask

    task automatic test_out_of_order();
        int          t0;
        int          exp_c[2];
        logic [1:0]  exp_t[2];
        logic [31:0] exp_d[2];
        drive(1'b1, 32'h0C, 2'd0, 32'hAAAA0000);
        drive(1'b1, 32'h00, 2'd0, 32'h00005555);
        idle(2);
        clear_log();
        drive(1'b0, 32'h0C, 2'd0, 32'h0);
        t0 = cyc;
        checks++;
        if (slave_ack !== 1'b1) begin
            errors++;
            $display("FAIL ooo_ack0: got %b expected 1", slave_ack);
        end
        drive(1'b0, 32'h00, 2'd1, 32'h0);
        checks++;
        if (slave_ack !== 1'b1) begin
            errors++;
            $display("FAIL ooo_ack1: got %b expected 1", slave_ack);
        end
        idle(10);
`ifdef PAVANA_MEM_SLAVE_INORDER_EN
        exp_c[0] = t0 + 3; exp_t[0] = 2'd0; exp_d[0] = 32'hAAAA0000;
        exp_c[1] = t0 + 4; exp_t[1] = 2'd1; exp_d[1] = 32'h00005555;
`else
        exp_c[0] = t0 + 4; exp_t[0] = 2'd1; exp_d[0] = 32'h00005555;
        exp_c[1] = t0 + 6; exp_t[1] = 2'd0; exp_d[1] = 32'hAAAA0000;
`endif
        checks++;
        if (rlog_cyc.size() != 2) begin
            errors++;
            $display("FAIL ooo_count: got %0d pulses expected 2", rlog_cyc.size());
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= rlog_cyc.size() || rlog_cyc[i] != exp_c[i] || rlog_tid[i] !== exp_t[i]
                || rlog_data[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL ooo_resp%0d: got cyc=+%0d tid=%0d data=%h expected cyc=+%0d tid=%0d data=%h",
                         i, (i < rlog_cyc.size()) ? rlog_cyc[i] - t0 : -1,
                         (i < rlog_tid.size()) ? rlog_tid[i] : 2'd0,
                         (i < rlog_data.size()) ? rlog_data[i] : 32'h0,
                         exp_c[i] - t0, exp_t[i], exp_d[i]);
            end
        end
        clear_log();
    endtask

`ifndef PAVANA_MEM_SLAVE_INORDER_EN
    task automatic test_full();
        int          t0;
        int          t1;
        int          exp_c[5];
        logic [1:0]  exp_t[5];
        logic [31:0] exp_d[5];
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h0C, 2'(k), 32'h0);
            if (k == 0) t0 = cyc;
            checks++;
            if (slave_ack !== 1'b1) begin
                errors++;
                $display("FAIL full_fill_ack%0d: got %b expected 1", k, slave_ack);
            end
        end
        // T+4: a read is refused, a write in the same cycle is accepted.
        drive(1'b0, 32'h00, 2'd0, 32'h0);
        checks++;
        if (slave_ack !== 1'b0) begin
            errors++;
            $display("FAIL full_rd_t4: got %b expected 0", slave_ack);
        end
        slave_cmd   = 1'b1;
        slave_addr  = 32'h20;
        slave_wdata = 32'h00001234;
        #1;
        checks++;
        if (slave_ack !== 1'b1) begin
            errors++;
            $display("FAIL full_wr_t4: got %b expected 1", slave_ack);
        end
        // T+5: slot 0 is being returned this cycle but is still counted as full.
        drive(1'b0, 32'h00, 2'd0, 32'h0);
        checks++;
        if (slave_ack !== 1'b0) begin
            errors++;
            $display("FAIL full_rd_t5: got %b expected 0", slave_ack);
        end
        drive(1'b0, 32'h00, 2'd0, 32'h0);
        checks++;
        if (slave_ack !== 1'b1 || cyc != t0 + 6) begin
            errors++;
            $display("FAIL full_rd_t6: got ack=%b at +%0d expected ack=1 at +6", slave_ack, cyc - t0);
        end
        idle(8);
        exp_c[0] = t0 + 6;  exp_t[0] = 2'd0; exp_d[0] = 32'hAAAA0000;
        exp_c[1] = t0 + 7;  exp_t[1] = 2'd1; exp_d[1] = 32'hAAAA0000;
        exp_c[2] = t0 + 8;  exp_t[2] = 2'd2; exp_d[2] = 32'hAAAA0000;
        exp_c[3] = t0 + 9;  exp_t[3] = 2'd0; exp_d[3] = 32'h00005555;
        exp_c[4] = t0 + 10; exp_t[4] = 2'd3; exp_d[4] = 32'hAAAA0000;
        checks++;
        if (rlog_cyc.size() != 5) begin
            errors++;
            $display("FAIL full_count: got %0d pulses expected 5", rlog_cyc.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= rlog_cyc.size() || rlog_cyc[i] != exp_c[i] || rlog_tid[i] !== exp_t[i]
                || rlog_data[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL full_resp%0d: got cyc=+%0d tid=%0d data=%h expected cyc=+%0d tid=%0d data=%h",
                         i, (i < rlog_cyc.size()) ? rlog_cyc[i] - t0 : -1,
                         (i < rlog_tid.size()) ? rlog_tid[i] : 2'd0,
                         (i < rlog_data.size()) ? rlog_data[i] : 32'h0,
                         exp_c[i] - t0, exp_t[i], exp_d[i]);
            end
        end
        clear_log();
        // The write accepted while full must have landed.
        drive(1'b0, 32'h20, 2'd1, 32'h0);
        t1 = cyc;
        idle(6);
        checks++;
        if (rlog_cyc.size() != 1 || rlog_cyc[0] != t1 + 3 || rlog_tid[0] !== 2'd1
            || rlog_data[0] !== 32'h00001234) begin
            errors++;
            $display("FAIL full_wr_landed: got %0d pulses data=%h expected 1 pulse cyc=+3 tid=1 data=00001234",
                     rlog_cyc.size(), (rlog_data.size() > 0) ? rlog_data[0] : 32'h0);
        end
        clear_log();
    endtask
`endif

    task automatic test_contention();
        int          t0;
        int          exp_c[2];
        logic [1:0]  exp_t[2];
        logic [31:0] exp_d[2];
        drive(1'b1, 32'h04, 2'd0, 32'h04040404);
        idle(2);
        clear_log();
        drive(1'b0, 32'h04, 2'd2, 32'h0);
        t0 = cyc;
        drive(1'b0, 32'h00, 2'd3, 32'h0);
        idle(8);
`ifdef PAVANA_MEM_SLAVE_INORDER_EN
        exp_c[0] = t0 + 3;
        exp_c[1] = t0 + 4;
`else
        exp_c[0] = t0 + 4;
        exp_c[1] = t0 + 5;
`endif
        exp_t[0] = 2'd2; exp_d[0] = 32'h04040404;
        exp_t[1] = 2'd3; exp_d[1] = 32'h00005555;
        checks++;
        if (rlog_cyc.size() != 2) begin
            errors++;
            $display("FAIL cont_count: got %0d pulses expected 2", rlog_cyc.size());
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= rlog_cyc.size() || rlog_cyc[i] != exp_c[i] || rlog_tid[i] !== exp_t[i]
                || rlog_data[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL cont_resp%0d: got cyc=+%0d tid=%0d data=%h expected cyc=+%0d tid=%0d data=%h",
                         i, (i < rlog_cyc.size()) ? rlog_cyc[i] - t0 : -1,
                         (i < rlog_tid.size()) ? rlog_tid[i] : 2'd0,
                         (i < rlog_data.size()) ? rlog_data[i] : 32'h0,
                         exp_c[i] - t0, exp_t[i], exp_d[i]);
            end
        end
        clear_log();
    endtask

    task automatic test_mid_reset();
        int t1;
        drive(1'b0, 32'h10, 2'd1, 32'h0);
        // Reset during the next cycle while a write is offered.
        drive(1'b1, 32'h10, 2'd0, 32'hBAD0BAD0);
        rst_i = 1'b1;
        #1;
        checks++;
        if (slave_ack !== 1'b0) begin
            errors++;
            $display("FAIL mrst_ack: got %b expected 0", slave_ack);
        end
        @(negedge clk_i);
        rst_i     = 1'b0;
        slave_req = 1'b0;
        slave_cmd = 1'b0;
        checks++;
        if (slave_resp !== 1'b0 || slave_resptid !== 2'd0 || slave_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mrst_outputs: got resp=%b tid=%0d data=%h expected 0/0/00000000",
                     slave_resp, slave_resptid, slave_rdata);
        end
        idle(8);
        checks++;
        if (rlog_cyc.size() != 0) begin
            errors++;
            $display("FAIL mrst_dropped: got %0d pulses expected 0", rlog_cyc.size());
        end
        clear_log();
        drive(1'b0, 32'h10, 2'd2, 32'h0);
        t1 = cyc;
        idle(6);
        checks++;
        if (rlog_cyc.size() != 1 || rlog_cyc[0] != t1 + 3 || rlog_tid[0] !== 2'd2
            || rlog_data[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL mrst_reread: got %0d pulses data=%h expected 1 pulse cyc=+3 tid=2 data=deadbeef",
                     rlog_cyc.size(), (rlog_data.size() > 0) ? rlog_data[0] : 32'h0);
        end
        clear_log();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_out_of_order();
`ifndef PAVANA_MEM_SLAVE_INORDER_EN
        test_full();
`endif
        test_contention();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
